// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state and flag-index definitions for the multi-cycle ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_NOT = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_LSL = 3'b101;
  localparam logic [2:0] OP_LSR = 3'b110;
  localparam logic [2:0] OP_ASR = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_V = 2;

endpackage

// File: rtl/AddSub.sv
// Two's-complement adder/subtractor with signed-overflow detection.
module AddSub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff = sub ? ~b : b;
  assign sum   = a + b_eff + WIDTH'(sub);
  // Overflow when both effective operands agree in sign but the sum does not.
  assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential shift-add unsigned multiplier: one partial product per cycle, WIDTH steps.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q, mcand_q, acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;

  // done_o flags the cycle of the final step; the product it exposes already
  // includes that step so the caller can register it on the same edge.
  assign acc_d        = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done_o       = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign {hi_o, lo_o} = acc_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      mplier_q <= b_i;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done_o) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/NOT/shifts, WIDTH-cycle MUL, registered result + flags.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [2:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [2:0]       Z
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [2:0]       z_q, z_d;

  logic             accept, mul_start, mul_done;
  logic [WIDTH-1:0] mul_lo, mul_hi;
  logic [WIDTH-1:0] as_sum;
  logic             as_ovf;
  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] res;
  logic             res_v;

  function automatic logic [2:0] flags(input logic [WIDTH-1:0] r, input logic v);
    logic [2:0] f;
    f        = '0;
    f[FLG_Z] = (r == '0);
    f[FLG_N] = r[WIDTH-1];
    f[FLG_V] = v;
    return f;
  endfunction

  assign amt       = Bin[SHW-1:0];
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (ALUop == OP_MUL);
  assign out       = out_q;
  assign Z         = z_q;

  AddSub #(.WIDTH(WIDTH)) u_addsub (
    .a   (Ain),
    .b   (Bin),
    .sub (ALUop == OP_SUB),
    .sum (as_sum),
    .ovf (as_ovf)
  );

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (reset_n),
    .start_i (mul_start),
    .a_i     (Ain),
    .b_i     (Bin),
    .done_o  (mul_done),
    .lo_o    (mul_lo),
    .hi_o    (mul_hi)
  );

  always_comb begin
    res   = '0;
    res_v = 1'b0;
    case (ALUop)
      OP_ADD:  begin res = as_sum; res_v = as_ovf; end
      OP_SUB:  begin res = as_sum; res_v = as_ovf; end
      OP_AND:  res = Ain & Bin;
      OP_NOT:  res = ~Bin;
      OP_LSL:  res = Ain << amt;
      OP_LSR:  res = Ain >> amt;
      OP_ASR:  res = $signed(Ain) >>> amt;
      default: res = '0;
    endcase
  end

  // An accept from DONE behaves exactly like one from IDLE, overriding the drain to IDLE.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    z_d     = z_q;
    case (state_q)
      ST_IDLE: ;
      ST_BUSY: begin
        if (mul_done) begin
          state_d = ST_DONE;
          out_d   = mul_lo;
          z_d     = flags(mul_lo, |mul_hi);
        end
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      if (ALUop == OP_MUL) begin
        state_d = ST_BUSY;
      end else begin
        state_d = ST_DONE;
        out_d   = res;
        z_d     = flags(res, res_v);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      z_q     <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      z_q     <= z_d;
    end
  end

endmodule
